// File: rtl/load_weight_bias_conv1x1_if.sv
// Parameter stream handshake carrying weight/bias/scale/shift beats into the loader.
// A beat transfers on a cycle where S_Para_Valid and S_Para_Ready are both high.
interface load_weight_bias_conv1x1_if #(
    parameter int AXI_WIDTH = 128
) ();
    logic [AXI_WIDTH-1:0] S_Para_Data;
    logic                 S_Para_Valid;
    logic                 S_Para_Ready;

    modport master (
        output S_Para_Data,
        output S_Para_Valid,
        input  S_Para_Ready
    );

    modport slave (
        input  S_Para_Data,
        input  S_Para_Valid,
        output S_Para_Ready
    );
endinterface

// File: rtl/load_weight_bias_conv1x1.sv
// Parameter loader for the 1x1 conv engine: streams weights/bias/scale(/shift) into RAMs
// and serves them on registered read ports. Define LWB_SHIFT_TABLE_EN to add the shift table.
module load_weight_bias_conv1x1 #(
    parameter int AXI_WIDTH            = 128,
    parameter int WIDTH_WEIGHT_NUM     = 17,
    parameter int WIDTH_WEIGHT_ADDR    = 11,
    parameter int WIDTH_BIAS_RAM_ADDRA = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Start_Pa,
    load_weight_bias_conv1x1_if.slave       s_para,
    input  logic [WIDTH_WEIGHT_NUM-1:0]     Weight_Single_Num_REG,
    input  logic [WIDTH_BIAS_RAM_ADDRA-1:0] Bias_Num_REG,
    output logic                            Write_Block_Complete,
    input  logic [WIDTH_WEIGHT_ADDR-1:0]    Weight_Addrb,
    output logic [2047:0]                   Data_Out_Weight,
    input  logic [WIDTH_BIAS_RAM_ADDRA-1:0] Bias_Addrb,
    output logic [255:0]                    Data_Out_Bias,
    output logic [255:0]                    Data_Out_Scale,
    output logic [255:0]                    Data_Out_Shift
);
    localparam int WEIGHT_W = 2048;
    localparam int TABLE_W  = 256;
    localparam int BEATS_W  = WEIGHT_W / AXI_WIDTH;
    localparam int BEATS_T  = TABLE_W / AXI_WIDTH;
    localparam int LB_W     = $clog2(BEATS_W);
    localparam int WN       = WIDTH_WEIGHT_NUM;
    localparam int WA       = WIDTH_WEIGHT_ADDR;
    localparam int BA       = WIDTH_BIAS_RAM_ADDRA;
    localparam logic [LB_W-1:0] LAST_BEAT_W = LB_W'(BEATS_W - 1);
    localparam logic [LB_W-1:0] LAST_BEAT_T = LB_W'(BEATS_T - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WEIGHT,
        S_BIAS,
        S_SCALE,
`ifdef LWB_SHIFT_TABLE_EN
        S_SHIFT,
`endif
        S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [WN-1:0]       r_weight_num, r_beat_cnt;
    logic [BA-1:0]       r_bias_num, r_line_cnt, r_t_waddr;
    logic [LB_W-1:0]     r_line_beat;
    logic [WA-1:0]       r_waddr, r_w_waddr;
    logic [WEIGHT_W-1:0] r_weight_asm, r_w_wdata, w_weight_line;
    logic [TABLE_W-1:0]  r_tab_asm, r_t_wdata, w_tab_line;
    logic                r_w_we, r_t_we_bias, r_t_we_scale;
`ifdef LWB_SHIFT_TABLE_EN
    logic                r_t_we_shift;
`endif

    logic w_accept, w_in_weight, w_in_table;
    logic w_weight_last, w_weight_wr, w_weight_end;
    logic w_tab_line_end, w_tab_end;

    assign w_accept    = s_para.S_Para_Valid && s_para.S_Para_Ready;
    assign w_in_weight = (r_state == S_WEIGHT);
`ifdef LWB_SHIFT_TABLE_EN
    assign w_in_table  = (r_state == S_BIAS) || (r_state == S_SCALE) || (r_state == S_SHIFT);
`else
    assign w_in_table  = (r_state == S_BIAS) || (r_state == S_SCALE);
`endif

    // A weight line is flushed when full or when the final beat arrives (partial, zero-padded).
    assign w_weight_last  = (r_beat_cnt == r_weight_num - WN'(1));
    assign w_weight_wr    = w_accept && w_in_weight && ((r_line_beat == LAST_BEAT_W) || w_weight_last);
    assign w_weight_end   = w_accept && w_in_weight && w_weight_last;
    assign w_tab_line_end = w_accept && w_in_table && (r_line_beat == LAST_BEAT_T);
    assign w_tab_end      = w_tab_line_end && (r_line_cnt == r_bias_num - BA'(1));

    // Merge the incoming beat into its LSB-first slot of the assembly registers.
    for (genvar gi = 0; gi < BEATS_W; gi++) begin : g_weight_slot
        assign w_weight_line[gi*AXI_WIDTH +: AXI_WIDTH] =
            (r_line_beat == LB_W'(gi)) ? s_para.S_Para_Data : r_weight_asm[gi*AXI_WIDTH +: AXI_WIDTH];
    end

    for (genvar gi = 0; gi < BEATS_T; gi++) begin : g_tab_slot
        assign w_tab_line[gi*AXI_WIDTH +: AXI_WIDTH] =
            (r_line_beat == LB_W'(gi)) ? s_para.S_Para_Data : r_tab_asm[gi*AXI_WIDTH +: AXI_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start_Pa) begin
                    if (Weight_Single_Num_REG != '0) begin
                        w_state_next = S_WEIGHT;
                    end else if (Bias_Num_REG != '0) begin
                        w_state_next = S_BIAS;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_WEIGHT: begin
                if (w_weight_end) begin
                    w_state_next = (r_bias_num != '0) ? S_BIAS : S_DONE;
                end
            end
            S_BIAS: begin
                if (w_tab_end) begin
                    w_state_next = S_SCALE;
                end
            end
            S_SCALE: begin
                if (w_tab_end) begin
`ifdef LWB_SHIFT_TABLE_EN
                    w_state_next = S_SHIFT;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef LWB_SHIFT_TABLE_EN
            S_SHIFT: begin
                if (w_tab_end) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_para.S_Para_Ready  = w_in_weight || w_in_table;
        Write_Block_Complete = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_weight_num <= '0;
            r_bias_num   <= '0;
            r_beat_cnt   <= '0;
            r_line_beat  <= '0;
            r_line_cnt   <= '0;
            r_waddr      <= '0;
            r_weight_asm <= '0;
            r_tab_asm    <= '0;
            r_w_we       <= 1'b0;
            r_w_waddr    <= '0;
            r_w_wdata    <= '0;
            r_t_we_bias  <= 1'b0;
            r_t_we_scale <= 1'b0;
`ifdef LWB_SHIFT_TABLE_EN
            r_t_we_shift <= 1'b0;
`endif
            r_t_waddr    <= '0;
            r_t_wdata    <= '0;
        end else begin
            r_w_we       <= 1'b0;
            r_t_we_bias  <= 1'b0;
            r_t_we_scale <= 1'b0;
`ifdef LWB_SHIFT_TABLE_EN
            r_t_we_shift <= 1'b0;
`endif
            if (r_state == S_IDLE) begin
                if (Start_Pa) begin
                    r_weight_num <= Weight_Single_Num_REG;
                    r_bias_num   <= Bias_Num_REG;
                end
                r_beat_cnt   <= '0;
                r_line_beat  <= '0;
                r_line_cnt   <= '0;
                r_waddr      <= '0;
                r_weight_asm <= '0;
                r_tab_asm    <= '0;
            end else if (w_accept && w_in_weight) begin
                r_beat_cnt <= r_beat_cnt + WN'(1);
                if (w_weight_wr) begin
                    r_w_we       <= 1'b1;
                    r_w_waddr    <= r_waddr;
                    r_w_wdata    <= w_weight_line;
                    r_waddr      <= r_waddr + WA'(1);
                    r_weight_asm <= '0;
                    r_line_beat  <= '0;
                end else begin
                    r_weight_asm <= w_weight_line;
                    r_line_beat  <= r_line_beat + LB_W'(1);
                end
            end else if (w_accept && w_in_table) begin
                if (w_tab_line_end) begin
                    r_t_we_bias  <= (r_state == S_BIAS);
                    r_t_we_scale <= (r_state == S_SCALE);
`ifdef LWB_SHIFT_TABLE_EN
                    r_t_we_shift <= (r_state == S_SHIFT);
`endif
                    r_t_waddr    <= r_line_cnt;
                    r_t_wdata    <= w_tab_line;
                    r_tab_asm    <= '0;
                    r_line_beat  <= '0;
                    r_line_cnt   <= w_tab_end ? '0 : r_line_cnt + BA'(1);
                end else begin
                    r_tab_asm   <= w_tab_line;
                    r_line_beat <= r_line_beat + LB_W'(1);
                end
            end
        end
    end

    // RAM arrays carry no reset so that contents survive a mid-load reset.
    logic [WEIGHT_W-1:0] r_weight_ram [0:(1<<WA)-1];
    logic [TABLE_W-1:0]  r_bias_ram   [0:(1<<BA)-1];
    logic [TABLE_W-1:0]  r_scale_ram  [0:(1<<BA)-1];

    always_ff @(posedge clk) begin
        if (r_w_we) begin
            r_weight_ram[r_w_waddr] <= r_w_wdata;
        end
        if (r_t_we_bias) begin
            r_bias_ram[r_t_waddr] <= r_t_wdata;
        end
        if (r_t_we_scale) begin
            r_scale_ram[r_t_waddr] <= r_t_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_Out_Weight <= '0;
            Data_Out_Bias   <= '0;
            Data_Out_Scale  <= '0;
        end else begin
            Data_Out_Weight <= r_weight_ram[Weight_Addrb];
            Data_Out_Bias   <= r_bias_ram[Bias_Addrb];
            Data_Out_Scale  <= r_scale_ram[Bias_Addrb];
        end
    end

`ifdef LWB_SHIFT_TABLE_EN
    logic [TABLE_W-1:0] r_shift_ram [0:(1<<BA)-1];

    always_ff @(posedge clk) begin
        if (r_t_we_shift) begin
            r_shift_ram[r_t_waddr] <= r_t_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_Out_Shift <= '0;
        end else begin
            Data_Out_Shift <= r_shift_ram[Bias_Addrb];
        end
    end
`else
    assign Data_Out_Shift = '0;
`endif

endmodule

// File: tb/tb_load_weight_bias_conv1x1.sv
// Bench for load_weight_bias_conv1x1: random parameter streams, a line-level memory model,
// and a read scoreboard. Honours LWB_SHIFT_TABLE_EN to decide whether shift lines are streamed.
module tb_load_weight_bias_conv1x1;
    localparam int AXI_WIDTH = 128;
    localparam int WN = 17;
    localparam int WA = 11;
    localparam int BA = 9;
`ifdef LWB_SHIFT_TABLE_EN
    localparam int NTAB = 3;
`else
    localparam int NTAB = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Start_Pa = 1'b0;
    logic [WN-1:0] Weight_Single_Num_REG = '0;
    logic [BA-1:0] Bias_Num_REG = '0;
    logic          Write_Block_Complete;
    logic [WA-1:0] Weight_Addrb = '0;
    logic [2047:0] Data_Out_Weight;
    logic [BA-1:0] Bias_Addrb = '0;
    logic [255:0]  Data_Out_Bias, Data_Out_Scale, Data_Out_Shift;

    load_weight_bias_conv1x1_if #(.AXI_WIDTH(AXI_WIDTH)) bus ();

    load_weight_bias_conv1x1 #(
        .AXI_WIDTH(AXI_WIDTH), .WIDTH_WEIGHT_NUM(WN),
        .WIDTH_WEIGHT_ADDR(WA), .WIDTH_BIAS_RAM_ADDRA(BA)
    ) dut (
        .clk(clk), .rst(rst), .Start_Pa(Start_Pa), .s_para(bus),
        .Weight_Single_Num_REG(Weight_Single_Num_REG), .Bias_Num_REG(Bias_Num_REG),
        .Write_Block_Complete(Write_Block_Complete),
        .Weight_Addrb(Weight_Addrb), .Data_Out_Weight(Data_Out_Weight),
        .Bias_Addrb(Bias_Addrb), .Data_Out_Bias(Data_Out_Bias),
        .Data_Out_Scale(Data_Out_Scale), .Data_Out_Shift(Data_Out_Shift)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int exp_pulses = 0;

    logic [AXI_WIDTH-1:0] stream[$];
    logic [2047:0] m_w  [int];
    logic [255:0]  m_b  [int];
    logic [255:0]  m_s  [int];
    logic [255:0]  m_sh [int];

    typedef struct {
        bit cw; bit ct; int wa; int ta;
        logic [2047:0] w; logic [255:0] b; logic [255:0] s; logic [255:0] sh;
    } exp_t;
    exp_t sbq[$];
    bit rd_issue = 1'b0;
    bit rd_pend = 1'b0;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input int addr, input logic [2047:0] act,
                              input logic [2047:0] exp);
        checks++;
        if (act !== exp) begin
            int k = 0;
            failures++;
            while (k < 15 && act[k*128 +: 128] === exp[k*128 +: 128]) k++;
            $display("FAIL %s addr=%0d chunk=%0d got=%h exp=%h", name, addr, k,
                     act[k*128 +: 128], exp[k*128 +: 128]);
        end
    endtask

    always @(negedge clk) if (Write_Block_Complete) pulses++;

    // Read monitor: data presented one cycle after the address is issued.
    always @(posedge clk) rd_pend = rd_issue;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow got=empty exp=entry");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.cw) check_wide("rd_weight", e.wa, Data_Out_Weight, e.w);
                if (e.ct) begin
                    check_wide("rd_bias",  e.ta, {1792'b0, Data_Out_Bias},  {1792'b0, e.b});
                    check_wide("rd_scale", e.ta, {1792'b0, Data_Out_Scale}, {1792'b0, e.s});
                    check_wide("rd_shift", e.ta, {1792'b0, Data_Out_Shift}, {1792'b0, e.sh});
                end
                $display("read wa=%0d(%0d) ta=%0d(%0d)", e.wa, e.cw, e.ta, e.ct);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_stream(input int wn, input int bn, input bit counting);
        stream.delete();
        for (int i = 0; i < wn + NTAB * bn * 2; i++) begin
            logic [AXI_WIDTH-1:0] b;
            b = counting ? {4{i[31:0]}} : {$urandom, $urandom, $urandom, $urandom};
            stream.push_back(b);
        end
    endtask

    // Model: weights fill 16-beat lines LSB-first with zero padding; then NTAB tables of bn 2-beat lines.
    function automatic void model_apply(input int wn, input int bn);
        for (int j = 0; j < (wn + 15) / 16; j++) begin
            logic [2047:0] line = '0;
            for (int k = 0; k < 16; k++) begin
                if (j * 16 + k < wn) line[k*128 +: 128] = stream[j*16 + k];
            end
            m_w[j] = line;
        end
        for (int t = 0; t < NTAB; t++) begin
            for (int l = 0; l < bn; l++) begin
                logic [255:0] tl;
                tl = {stream[wn + (t*bn + l)*2 + 1], stream[wn + (t*bn + l)*2]};
                if (t == 0) m_b[l] = tl;
                else if (t == 1) m_s[l] = tl;
                else m_sh[l] = tl;
            end
        end
    endfunction

    task automatic start_load(input int wn, input int bn);
        Weight_Single_Num_REG = WN'(wn);
        Bias_Num_REG = BA'(bn);
        Start_Pa = 1'b1;
        tick();
        Start_Pa = 1'b0;
        Weight_Single_Num_REG = WN'($urandom);
        Bias_Num_REG = BA'($urandom);
        @(negedge clk);
        check1("ready_after_start", 64'(bus.S_Para_Ready), 64'(wn != 0 || bn != 0));
        if (wn == 0 && bn == 0) check1("zero_pulse", 64'(Write_Block_Complete), 64'd1);
        tick();
    endtask

    task automatic send_stream(input int n, input bit gaps, input bit poke_start);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        bit acc;
        while (i < n && guard < 4 * n + 20) begin
            bus.S_Para_Valid = gaps ? ph : 1'b1;
            ph = ~ph;
            bus.S_Para_Data = stream[i];
            Start_Pa = poke_start && (i < n - 1);
            @(negedge clk);
            acc = bus.S_Para_Valid && bus.S_Para_Ready;
            tick();
            if (acc) i++;
            guard++;
        end
        bus.S_Para_Valid = 1'b0;
        Start_Pa = 1'b0;
        check1("beats_accepted", 64'(i), 64'(n));
    endtask

    task automatic finish_load(input int wn, input int bn);
        @(negedge clk);
        check1("done_pulse", 64'(Write_Block_Complete), 64'd1);
        check1("done_ready", 64'(bus.S_Para_Ready), 64'd0);
        @(negedge clk);
        check1("pulse_width", 64'(Write_Block_Complete), 64'd0);
        tick();
        model_apply(wn, bn);
        exp_pulses++;
        $display("load wn=%0d bn=%0d beats=%0d", wn, bn, stream.size());
    endtask

    task automatic full_load(input int wn, input int bn, input bit gaps, input bit poke);
        start_load(wn, bn);
        send_stream(stream.size(), gaps, poke);
        finish_load(wn, bn);
    endtask

    task automatic read_lines(input int nw, input int nt);
        int n = (nw > nt) ? nw : nt;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.cw = (i < nw); e.ct = (i < nt); e.wa = i; e.ta = i;
            e.w = e.cw ? m_w[i] : '0;
            e.b = e.ct ? m_b[i] : '0;
            e.s = e.ct ? m_s[i] : '0;
`ifdef LWB_SHIFT_TABLE_EN
            e.sh = e.ct ? m_sh[i] : '0;
`else
            e.sh = '0;
`endif
            Weight_Addrb = WA'(i);
            Bias_Addrb = BA'(i);
            sbq.push_back(e);
            rd_issue = 1'b1;
            tick();
        end
        rd_issue = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int bp_wn, bp_bn;
        logic [AXI_WIDTH-1:0] dq[$];
        bus.S_Para_Valid = 1'b0;
        bus.S_Para_Data = '0;

        @(negedge clk);
        check1("rst_ready", 64'(bus.S_Para_Ready), 64'd0);
        check1("rst_complete", 64'(Write_Block_Complete), 64'd0);
        check_wide("rst_dout_w", 0, Data_Out_Weight, '0);
        check_wide("rst_dout_t", 0, {1280'b0, Data_Out_Bias, Data_Out_Scale, Data_Out_Shift}, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick();

        // Reset in the middle of the weight phase.
        gen_stream(32, 0, 1'b1);
        start_load(32, 0);
        send_stream(5, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check1("rst_mid_ready", 64'(bus.S_Para_Ready), 64'd0);
        check1("rst_mid_complete", 64'(Write_Block_Complete), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        $display("load reset after 5 beats");

        // Two full weight lines, counting pattern.
        gen_stream(32, 0, 1'b1);
        full_load(32, 0, 1'b0, 1'b0);
        read_lines(2, 0);

        // Partial second line zero-padded.
        gen_stream(20, 0, 1'b0);
        full_load(20, 0, 1'b0, 1'b0);
        read_lines(2, 0);

        // One weight line plus three lines per table.
        gen_stream(16, 3, 1'b0);
        full_load(16, 3, 1'b0, 1'b0);
        read_lines(1, 3);

        // Weight phase skipped.
        gen_stream(0, 2, 1'b0);
        full_load(0, 2, 1'b0, 1'b0);
        read_lines(0, 2);

        // Start_Pa asserted during the weight phase must not restart the load.
        gen_stream(16, 0, 1'b0);
        full_load(16, 0, 1'b0, 1'b1);
        read_lines(1, 0);

        // Back-to-back, then different data, then same data with Valid gaps.
        bp_wn = $urandom_range(17, 40);
        bp_bn = $urandom_range(1, 4);
        gen_stream(bp_wn, bp_bn, 1'b0);
        dq = stream;
        full_load(bp_wn, bp_bn, 1'b0, 1'b0);
        read_lines((bp_wn + 15) / 16, bp_bn);
        gen_stream(bp_wn, bp_bn, 1'b0);
        full_load(bp_wn, bp_bn, 1'b0, 1'b0);
        stream = dq;
        full_load(bp_wn, bp_bn, 1'b1, 1'b0);
        read_lines((bp_wn + 15) / 16, bp_bn);

        // All counts zero: no Ready, pulse the cycle after start.
        start_load(0, 0);
        check1("zero_pulse_width", 64'(Write_Block_Complete), 64'd0);
        check1("zero_ready", 64'(bus.S_Para_Ready), 64'd0);
        exp_pulses++;
        $display("load wn=0 bn=0 beats=0");

        tick();
        tick();
        check1("pulse_count", 64'(pulses), 64'(exp_pulses));
        check1("sb_drain", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
